expr_stream_gen: RTL and testbench

- Transmit-side counterpart of the character-stream expression checker.
- Takes an expression given as packed operands and operators, and emits it as ASCII one character per beat: digit (op digit)*.
- Uses a valid/ready handshake, so the output can drive the checker's 8-bit character input directly or feed a buffer.
- Every completed stream is a well-formed expression.

---
 rtl/expr_stream_gen_pkg.sv | 16 +
 rtl/expr_stream_gen_enc.sv | 22 ++
 rtl/expr_stream_gen.sv | 136 +++++++++++++
 tb/tb_expr_stream_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_stream_gen_pkg.sv
// Shared constants for the expression stream generator and checker.
// ASCII codes and FSM state encodings.
package expr_stream_gen_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DIGIT = 2'b01,
    OP    = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/expr_stream_gen_enc.sv
// Character encoder: maps state plus selected digit/op to ASCII.
// Idle and done states produce 8'h00.
module expr_char_enc
  import expr_stream_gen_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] dig,
  input  logic       op,
  output logic [7:0] ch
);

  // pick the character for the current beat
  always_comb begin
    ch = '0;
    unique case (state)
      DIGIT:   ch = CH_ZERO + {4'b0000, dig};
      OP:      ch = op ? CH_STAR : CH_PLUS;
      default: ch = '0;
    endcase
  end

endmodule

// File: rtl/expr_stream_gen.sv
// Expression stream generator: emits digit (op digit)* as ASCII.
// Valid/ready output; all outputs come from registered state.
module expr_stream_gen
  import expr_stream_gen_pkg::*;
#(
  parameter int MAX_OPND = 8,
  parameter int CW       = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [CW-1:0]         count,
  input  logic [4*MAX_OPND-1:0] digits,
  input  logic [MAX_OPND-2:0]   ops,
  input  logic                  ready,
  output logic [7:0]            out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         idx;
  logic [CW-1:0]         idx_n;
  logic [CW-1:0]         cnt_q;
  logic [4*MAX_OPND-1:0] dig_q;
  logic [MAX_OPND-2:0]   ops_q;
  logic                  err_q;
  logic                  err_n;
  logic                  load;
  logic                  ok;
  logic [3:0]            dig_sel;
  logic                  op_sel;

  // a start is legal when count is in range and used digits are BCD
  always_comb begin
    ok = (count != '0) && (count <= CW'(MAX_OPND));
    for (int i = 0; i < MAX_OPND; i++) begin
      if (CW'(i) < count && digits[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end
    end
  end

  // next state, index step, load and reject decisions
  always_comb begin
    state_n = state;
    idx_n   = idx;
    load    = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (ok) begin
            load    = 1'b1;
            idx_n   = '0;
            state_n = DIGIT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      DIGIT: begin
        if (ready) begin
          if (idx == cnt_q - CW'(1)) state_n = DONE;
          else state_n = OP;
        end
      end
      OP: begin
        if (ready) begin
          idx_n   = idx + CW'(1);
          state_n = DIGIT;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state and index registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // expression latch, written only on an accepted start
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
      dig_q <= '0;
      ops_q <= '0;
    end else if (load) begin
      cnt_q <= count;
      dig_q <= digits;
      ops_q <= ops;
    end
  end

  // registered reject pulse
  always_ff @(posedge clk or posedge clr) begin
    if (clr) err_q <= 1'b0;
    else err_q <= err_n;
  end

  // select the operand and operator at idx
  always_comb begin
    dig_sel = '0;
    op_sel  = 1'b0;
    for (int i = 0; i < MAX_OPND; i++) begin
      if (idx == CW'(i)) dig_sel = dig_q[4*i +: 4];
    end
    for (int i = 0; i < MAX_OPND - 1; i++) begin
      if (idx == CW'(i)) op_sel = ops_q[i];
    end
  end

  expr_char_enc u_enc (
    .state (state),
    .dig   (dig_sel),
    .op    (op_sel),
    .ch    (out)
  );

  assign out_valid = (state == DIGIT) || (state == OP);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_expr_stream_gen.sv
// Testbench for expr_stream_gen: scoreboard of expected characters.
// Each task drives one scenario and checks inline.
module tb_expr_stream_gen;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [3:0]  count;
  logic [31:0] digits;
  logic [6:0]  ops;
  logic        ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        err;

  logic [7:0] sbq[$];
  int tot = 0;
  int bad = 0;

  expr_stream_gen #(.MAX_OPND(8), .CW(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .count     (count),
    .digits    (digits),
    .ops       (ops),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

  // transferred beats are popped from the scoreboard
  logic [7:0] exp_ch;
  always @(negedge clk) begin
    if (!clr && out_valid && ready) begin
      tot++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL beat_extra: got %h, required no beat", out);
      end else begin
        exp_ch = sbq.pop_front();
        if (out !== exp_ch) begin
          bad++;
          $display("FAIL beat: got %h, required %h", out, exp_ch);
        end
      end
    end
  end

  task automatic launch(input logic [3:0] c, input logic [31:0] d,
                        input logic [6:0] o);
    @(posedge clk);
    #1;
    start  = 1'b1;
    count  = c;
    digits = d;
    ops    = o;
    @(posedge clk);
    #1;
    start  = 1'b0;
    count  = 4'hF;
    digits = 32'hFFFF_FFFF;
    ops    = 7'h55;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; start = 1'b0; ready = 1'b1;
    count = '0; digits = '0; ops = '0;
    repeat (2) @(negedge clk);
    tot++;
    if ({out, out_valid, busy, done, err} !== 12'h000) begin
      bad++;
      $display("FAIL reset: got %h/%b%b%b%b, required 00/0000",
               out, out_valid, busy, done, err);
    end
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic test_single;
    sbq.push_back(8'h37);
    launch(4'd1, 32'hFFFF_FFF7, 7'h00);
    @(negedge clk);
    tot++;
    if (out_valid !== 1'b1 || out !== 8'h37 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_beat: got %h v=%b b=%b, required 37 v=1 b=1",
               out, out_valid, busy);
    end
    @(negedge clk);
    tot++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_done: got d=%b v=%b b=%b, required 1 0 1",
               done, out_valid, busy);
    end
    @(negedge clk);
    tot++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got d=%b b=%b, required 0 0",
               done, busy);
    end
    tot++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL single_left: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_stream;
    int n;
    sbq.push_back(8'h31); sbq.push_back(8'h2B);
    sbq.push_back(8'h32); sbq.push_back(8'h2A);
    sbq.push_back(8'h33);
    launch(4'd3, 32'h0000_0321, 7'b0000010);
    wait_done(20, n);
    tot++;
    if (n != 6) begin
      bad++;
      $display("FAIL stream_done_at: got %0d, required 6", n);
    end
    tot++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL stream_left: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_backpressure;
    int n;
    sbq.push_back(8'h31); sbq.push_back(8'h2B);
    sbq.push_back(8'h32); sbq.push_back(8'h2A);
    sbq.push_back(8'h33);
    launch(4'd3, 32'h0000_0321, 7'b0000010);
    @(posedge clk);
    #1 ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tot++;
      if (out !== 8'h2B || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold: got %h v=%b, required 2b v=1",
                 out, out_valid);
      end
    end
    @(posedge clk);
    #1 ready = 1'b1;
    wait_done(20, n);
    tot++;
    if (n != 5) begin
      bad++;
      $display("FAIL stall_done_at: got %0d, required 5", n);
    end
    tot++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL stall_left: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_err;
    logic [3:0]  cs[3];
    logic [31:0] ds[3];
    cs[0] = 4'd2; ds[0] = 32'h0000_00A5;
    cs[1] = 4'd0; ds[1] = 32'h0000_0000;
    cs[2] = 4'd9; ds[2] = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      launch(cs[k], ds[k], 7'h00);
      @(negedge clk);
      tot++;
      if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL err_pulse%0d: got e=%b v=%b b=%b, required 1 0 0",
                 k, err, out_valid, busy);
      end
      @(negedge clk);
      tot++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL err_clear%0d: got e=%b v=%b, required 0 0",
                 k, err, out_valid);
      end
    end
  endtask

  task automatic test_clr;
    int n;
    logic seen;
    sbq.push_back(8'h31); sbq.push_back(8'h2B);
    sbq.push_back(8'h32); sbq.push_back(8'h2A);
    sbq.push_back(8'h33);
    launch(4'd3, 32'h0000_0321, 7'b0000010);
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    tot++;
    if ({out, out_valid, busy, done, err} !== 12'h000) begin
      bad++;
      $display("FAIL clr_async: got %h/%b%b%b%b, required 00/0000",
               out, out_valid, busy, done, err);
    end
    #1 clr = 1'b0;
    tot++;
    if (sbq.size() != 3) begin
      bad++;
      $display("FAIL clr_progress: got %0d pending, required 3", sbq.size());
    end
    sbq.delete();
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || out_valid) seen = 1'b1;
    end
    tot++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL clr_quiet: got activity=1, required 0");
    end
    sbq.push_back(8'h38); sbq.push_back(8'h2A); sbq.push_back(8'h39);
    launch(4'd2, 32'h0000_0098, 7'b0000001);
    wait_done(10, n);
    tot++;
    if (n != 4) begin
      bad++;
      $display("FAIL clr_restart: got %0d, required 4", n);
    end
    tot++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL clr_left: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_max;
    int n;
    logic [31:0] d;
    d = 32'h2345_6789;
    for (int i = 0; i < 8; i++) begin
      sbq.push_back(8'h30 + {4'h0, d[4*i +: 4]});
      if (i < 7) sbq.push_back(8'h2A);
    end
    launch(4'd8, d, 7'h7F);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; count = 4'd1; digits = 32'h0000_0005;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(30, n);
    tot++;
    if (n != 11) begin
      bad++;
      $display("FAIL max_done_at: got %0d, required 11", n);
    end
    @(negedge clk);
    tot++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL max_after: got v=%b b=%b e=%b, required 0 0 0",
               out_valid, busy, err);
    end
    tot++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL max_left: got %0d pending, required 0", sbq.size());
    end
  endtask

  task automatic test_back_to_back;
    int first;
    int second;
    first = -1;
    second = -1;
    sbq.push_back(8'h33); sbq.push_back(8'h33);
    @(posedge clk);
    #1;
    start = 1'b1; count = 4'd1; digits = 32'h0000_0003;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = i;
        else if (second < 0) begin
          second = i;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    tot++;
    if (second - first != 3) begin
      bad++;
      $display("FAIL b2b_gap: got %0d, required 3", second - first);
    end
    repeat (3) @(negedge clk);
    tot++;
    if (sbq.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_left: got %0d pending b=%b, required 0 0",
               sbq.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_err();
    test_clr();
    test_max();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
